multi_tick_gen: RTL and testbench

//  Parametrised successor of the single fixed-period tick generator.
//  NCH independent channels, each a one-clk tick pulse every DIV counted cycles.
//  DIV is runtime-writable per channel; channels support pause/resume and a

---
 rtl/multi_tick_gen_pkg.sv | 11 +
 rtl/multi_tick_gen_tick_channel.sv | 58 +++++
 rtl/multi_tick_gen.sv | 51 +++++
 tb/tb_multi_tick_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
package multi_tick_pkg;
  localparam int   DEFAULT_DIV_C = 5;
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Width needed to index n items; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/multi_tick_gen_tick_channel.sv
// One tick channel: divisor register, counter, tick/done flags and en edge detector.
module tick_channel
  import multi_tick_pkg::*;
#(
  parameter int W           = 26,
  parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         en,
  input  logic         oneshot,
  input  logic         load,
  input  logic [W-1:0] load_div,
  input  logic         clear,
  output logic         tick,
  output logic         done,
  output logic         busy
);
  logic [W-1:0] div, cnt, last;
  logic         en_q, rise;

  // A divisor of 0 behaves like 1.
  assign last = (div == '0) ? '0 : div - W'(1);
  assign rise = en & ~en_q;
  assign busy = en & ~done;

  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= W'(DEFAULT_DIV);
      cnt  <= '0;
      tick <= 1'b0;
      done <= 1'b0;
      en_q <= 1'b0;
    end else begin
      en_q <= en;
      if (clear || load) begin
        if (load) div <= load_div;
        cnt  <= '0;
        done <= 1'b0;
        tick <= 1'b0;
      end else begin
        tick <= 1'b0;
        if (rise) done <= 1'b0;
        // A rising en re-arms a finished one-shot and counts in the same cycle.
        if (en && ce && (!done || rise)) begin
          if (cnt == last) begin
            cnt  <= '0;
            tick <= 1'b1;
            if (oneshot == MODE_ONESHOT) done <= 1'b1;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
      end
    end
  end
endmodule

// File: rtl/multi_tick_gen.sv
// NCH independent tick channels sharing one prescaler, a divisor write port and a global sync.
module multi_tick_gen
  import multi_tick_pkg::*;
#(
  parameter  int NCH         = 4,
  parameter  int W           = 26,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_C,
  parameter  int PRE         = 1,
  localparam int CW          = clog2_min1(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] en,
  input  logic [NCH-1:0] oneshot,
  input  logic           wr_en,
  input  logic [CW-1:0]  wr_ch,
  input  logic [W-1:0]   wr_div,
  input  logic           sync,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] busy
);
  localparam int PW = clog2_min1(PRE);

  logic [PW-1:0] pre_cnt;
  logic          ce;

  assign ce = (pre_cnt == PW'(PRE - 1));

  always_ff @(posedge clk) begin
    if (reset || sync) pre_cnt <= '0;
    else               pre_cnt <= ce ? '0 : pre_cnt + PW'(1);
  end

  // Out-of-range wr_ch matches no channel and is dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tick_channel #(.W(W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .ce      (ce),
      .en      (en[i]),
      .oneshot (oneshot[i]),
      .load    (wr_en && (wr_ch == CW'(i))),
      .load_div(wr_div),
      .clear   (sync),
      .tick    (tick[i]),
      .done    (done[i]),
      .busy    (busy[i])
    );
  end
endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed + random bench for multi_tick_gen against an elapsed-count reference model.
module tb_multi_tick_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  en, oneshot;
  logic        wr_en, sync;
  logic [1:0]  wr_ch;
  logic [25:0] wr_div;
  logic [3:0]  tick_a, done_a, busy_a;
  logic [2:0]  tick_b, done_b, busy_b;

  int checks = 0;
  int errors = 0;

  // Reference state: [0] = 4 channels PRE=1, [1] = 3 channels PRE=3.
  int m_div[2][4];
  int m_el[2][4];
  bit m_done[2][4], m_tick[2][4], m_enq[2][4];
  int m_since[2];

  always #5 clk = ~clk;

  multi_tick_gen #(.NCH(4), .W(26), .DEFAULT_DIV(5), .PRE(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .oneshot(oneshot), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_div(wr_div), .sync(sync),
    .tick(tick_a), .done(done_a), .busy(busy_a)
  );

  multi_tick_gen #(.NCH(3), .W(26), .DEFAULT_DIV(5), .PRE(3)) dut_b (
    .clk(clk), .reset(reset), .en(en[2:0]), .oneshot(oneshot[2:0]), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_div(wr_div), .sync(sync),
    .tick(tick_b), .done(done_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock edge of the reference: ticks occur every D-th counted cycle.
  task automatic model_step(input int m, input int pre, input int nch);
    bit ce;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_div[m][i] = 5; m_el[m][i] = 0;
        m_done[m][i] = 0; m_tick[m][i] = 0; m_enq[m][i] = 0;
      end
      m_since[m] = 0;
      return;
    end
    ce = ((m_since[m] % pre) == pre - 1);
    m_since[m] = sync ? 0 : m_since[m] + 1;
    for (int i = 0; i < nch; i++) begin
      int d;
      bit hit;
      d   = (m_div[m][i] == 0) ? 1 : m_div[m][i];
      hit = wr_en && (int'(wr_ch) == i);
      if (sync || hit) begin
        if (hit) m_div[m][i] = int'(wr_div);
        m_el[m][i] = 0; m_done[m][i] = 0; m_tick[m][i] = 0;
      end else begin
        m_tick[m][i] = 0;
        if (en[i] && !m_enq[m][i]) m_done[m][i] = 0;
        if (en[i] && ce && !m_done[m][i]) begin
          m_el[m][i]++;
          if (m_el[m][i] >= d) begin
            m_el[m][i] = 0;
            m_tick[m][i] = 1;
            if (oneshot[i]) m_done[m][i] = 1;
          end
        end
      end
      m_enq[m][i] = en[i];
    end
  endtask

  task automatic check_all();
    logic [3:0] et, ed, eb;
    logic [2:0] ft, fd, fb;
    for (int i = 0; i < 4; i++) begin
      et[i] = m_tick[0][i]; ed[i] = m_done[0][i]; eb[i] = en[i] & ~m_done[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      ft[i] = m_tick[1][i]; fd[i] = m_done[1][i]; fb[i] = en[i] & ~m_done[1][i];
    end
    chk("a_tick", 32'(tick_a), 32'(et));
    chk("a_done", 32'(done_a), 32'(ed));
    chk("a_busy", 32'(busy_a), 32'(eb));
    chk("b_tick", 32'(tick_b), 32'(ft));
    chk("b_done", 32'(done_b), 32'(fd));
    chk("b_busy", 32'(busy_b), 32'(fb));
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, 1, 4);
    model_step(1, 3, 3);
    @(negedge clk);
    check_all();
  endtask

  task automatic wr(input int ch, input int dv);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_div = 26'(dv);
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [31:0] mask;
    reset = 1'b1; en = '0; oneshot = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; sync = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    chk("reset_tick", 32'(tick_a), 32'h0);
    chk("reset_done", 32'(done_a), 32'h0);

    // 1: ch0 default div 5 ticks at cycles 5, 10, 15
    en = 4'b0001; mask = '0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (tick_a[0]) mask[k] = 1'b1;
      chk("t1_other", 32'(tick_a[3:1]), 32'h0);
    end
    chk("t1_cycles", mask, (32'd1 << 5) | (32'd1 << 10) | (32'd1 << 15));
    chk("t1_busy", 32'(busy_a), 32'h1);

    // 2: ch1 at cnt=2 rewritten to div 3
    en = 4'b0011;
    step(); step();
    wr(1, 3);
    mask = '0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (tick_a[1]) mask[k] = 1'b1;
    end
    chk("t2_cycles", mask, (32'd1 << 3) | (32'd1 << 6));

    // 3: ch2 one-shot, div 4
    en = 4'b0000; oneshot = 4'b0100;
    wr(2, 4);
    en = 4'b0100; mask = '0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (tick_a[2]) mask[k] = 1'b1;
    end
    chk("t3_single", mask, 32'd1 << 4);
    chk("t3_done", 32'(done_a[2]), 32'h1);
    chk("t3_busy", 32'(busy_a[2]), 32'h0);
    en = 4'b0000; step();
    en = 4'b0100; mask = '0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) chk("t3_rearm", 32'(done_a[2]), 32'h0);
      if (tick_a[2]) mask[k] = 1'b1;
    end
    chk("t3_again", mask, 32'd1 << 4);
    oneshot = '0; en = '0;

    // 4: ch0 paused 2 cycles at cnt=2
    wr(0, 5);
    en = 4'b0001;
    step(); step();
    mask = '0;
    for (int k = 1; k <= 11; k++) begin
      en[0] = (k <= 2) ? 1'b0 : 1'b1;
      step();
      if (tick_a[0]) mask[k] = 1'b1;
    end
    chk("t4_delay", mask, (32'd1 << 5) | (32'd1 << 10));

    // 5: ch0/ch1 div 6 started apart, realigned by sync; invalid write on dut_b
    en = '0;
    wr(0, 6);
    en = 4'b0001; step();
    wr(1, 6);
    en = 4'b0011; step(); step();
    sync = 1'b1; step(); sync = 1'b0;
    mask = '0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (tick_a[1:0] == 2'b11) mask[k] = 1'b1;
      else if (tick_a[1:0] != 2'b00) mask[31] = 1'b1;
    end
    chk("t5_sync", mask, 32'd1 << 6);
    wr(3, 1);
    for (int k = 0; k < 4; k++) step();

    // 6: ch3 div 0 then div 1 tick every cycle; reset mid-run
    en = 4'b1000;
    wr(3, 0);
    for (int k = 0; k < 4; k++) begin step(); chk("t6_div0", 32'(tick_a[3]), 32'h1); end
    wr(3, 1);
    for (int k = 0; k < 4; k++) begin step(); chk("t6_div1", 32'(tick_a[3]), 32'h1); end
    reset = 1'b1; step(); reset = 1'b0;
    chk("t6_reset", 32'(tick_a), 32'h0);
    mask = '0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (tick_a[3]) mask[k] = 1'b1;
    end
    chk("t6_period5", mask, (32'd1 << 5) | (32'd1 << 10));

    // PRE=3 instance, div 2: ticks 6 clk apart
    en = '0;
    wr(0, 2);
    en = 4'b0001; mask = '0;
    begin
      int first, second;
      first = -1; second = -1;
      for (int k = 1; k <= 20; k++) begin
        step();
        if (tick_b[0]) begin
          if (first < 0) first = k;
          else if (second < 0) second = k;
        end
      end
      chk("pre3_period", 32'(second - first), 32'd6);
    end

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 4; i++) begin
        en[i]      = ($urandom_range(0, 9) < 8);
        oneshot[i] = ($urandom_range(0, 9) < 2);
      end
      wr_en  = ($urandom_range(0, 9) == 0);
      wr_ch  = 2'($urandom_range(0, 3));
      wr_div = 26'($urandom_range(0, 7));
      sync   = ($urandom_range(0, 49) == 0);
      reset  = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; wr_en = 1'b0; sync = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
